// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the Uart8 receiver/consumer and the receive FIFO.
// The master drives received bytes and consumer controls; the slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rxDone;
    logic              rxErr;
    logic [7:0]        rxByte;
    logic              rdEn;
    logic              clrOverflow;
    logic [7:0]        rdData;
    logic              rdErr;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output rxDone, rxErr, rxByte, rdEn, clrOverflow,
        input  rdData, rdErr, empty, full, count, overflow
    );

    modport slave (
        input  rxDone, rxErr, rxByte, rdEn, clrOverflow,
        output rdData, rdErr, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the Uart8 receiver: stores {err,byte} on each rxDone rising edge,
// presents the head entry first-word-fall-through, tracks occupancy and sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_fifo_if.slave    bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              rxDonePrev;

    logic push;
    logic pop;
    logic accept;
    logic drop;
    logic empty;
    logic full;

    // Occupancy flags come from the registered count so a full FIFO never looks empty.
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);
    assign push   = bus.rxDone & ~rxDonePrev;
    assign pop    = bus.rdEn & ~empty;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rxDonePrev <= 1'b0;
        end else begin
            rxDonePrev <= bus.rxDone;
            if (accept) wrPtr <= wrPtr + ADDR_W'(1);
            if (pop)    rdPtr <= rdPtr + ADDR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)                 overflow <= 1'b1;
            else if (bus.clrOverflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wrPtr] <= {bus.rxErr, bus.rxByte};
    end

    assign {bus.rdErr, bus.rdData} = empty ? 9'd0 : mem[rdPtr];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count;
    assign bus.overflow = overflow;

    countInRange: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_CNT);

endmodule
